// File: rtl/instruction_fetch_unit_pkg.sv
//----------------------------------------------------------------------------
// Module : instruction_fetch_unit_pkg
// Brief  : Shared constants, FSM encoding and helpers for the fetch unit.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

package instruction_fetch_unit_pkg;

  localparam int          c_INSTR_W        = 32;
  localparam int          c_OPC_MSB        = 31;
  localparam int          c_OPC_LSB        = 26;
  localparam int          c_OPC_W          = c_OPC_MSB - c_OPC_LSB + 1;
  localparam logic [5:0]  c_BUBBLE_OPCODE  = 6'b111111;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/instruction_fetch_unit_program_counter.sv
//----------------------------------------------------------------------------
// Module : program_counter
// Brief  : PC register with +4 incrementer and word-aligned redirect mux.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module program_counter
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        advance,
  input  logic        redirect,
  input  logic [31:0] target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_target_aligned;

  // Modulo-2^32 add: the top word wraps to zero without any flag.
  assign w_pc_plus4       = r_pc + 32'd4;
  assign w_target_aligned = word_align(target);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_pc <= word_align(RESET_PC);
    end else if (redirect) begin
      r_pc <= w_target_aligned;
    end else if (advance) begin
      r_pc <= w_pc_plus4;
    end
  end

  assign pc       = r_pc;
  assign pc_plus4 = w_pc_plus4;

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
//----------------------------------------------------------------------------
// Module : instruction_fetch_unit
// Brief  : PC, req/ack instruction fetch, one-entry skid buffer and IF/ID reg.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter logic [5:0]  BUBBLE_OPCODE = c_BUBBLE_OPCODE
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic [31:0] Instruction,
  output logic [5:0]  OpCode,
  output logic [31:0] PCPlus4,
  output logic        InstrValid
);

  fetch_state_e           r_state;
  logic [c_INSTR_W-1:0]   r_instr;
  logic [c_OPC_W-1:0]     r_opcode;
  logic [31:0]            r_pcplus4;
  logic                   r_valid;
  logic [c_INSTR_W-1:0]   r_skid;
  logic [31:0]            r_skid_pc4;

  logic [31:0]            w_pc;
  logic [31:0]            w_pc_plus4;
  logic                   w_ack;
  logic                   w_advance;

  // Ack only counts while a request is open; a branch drops it.
  assign w_ack     = IMemAck && (r_state == FETCH);
  assign w_advance = w_ack && !BranchTaken;

  program_counter #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .Clk      (Clk),
    .Rst      (Rst),
    .advance  (w_advance),
    .redirect (BranchTaken),
    .target   (BranchTarget),
    .pc       (w_pc),
    .pc_plus4 (w_pc_plus4)
  );

  assign IMemReq  = (r_state == FETCH);
  assign IMemAddr = w_pc;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state    <= FETCH;
      r_instr    <= '0;
      r_opcode   <= BUBBLE_OPCODE;
      r_pcplus4  <= '0;
      r_valid    <= 1'b0;
      r_skid     <= '0;
      r_skid_pc4 <= '0;
    end else if (BranchTaken) begin
      // Redirect wins over stall and ack; any skid contents are simply abandoned.
      r_state  <= FETCH;
      r_valid  <= 1'b0;
      r_opcode <= BUBBLE_OPCODE;
    end else begin
      case (r_state)
        FETCH: begin
          if (w_ack && !Stall) begin
            r_instr   <= IMemData;
            r_opcode  <= IMemData[c_OPC_MSB:c_OPC_LSB];
            r_pcplus4 <= w_pc_plus4;
            r_valid   <= 1'b1;
          end else if (w_ack && Stall) begin
            r_skid     <= IMemData;
            r_skid_pc4 <= w_pc_plus4;
            r_state    <= HOLD;
          end else if (!Stall) begin
            r_valid  <= 1'b0;
            r_opcode <= BUBBLE_OPCODE;
          end
        end
        HOLD: begin
          if (!Stall) begin
            r_instr   <= r_skid;
            r_opcode  <= r_skid[c_OPC_MSB:c_OPC_LSB];
            r_pcplus4 <= r_skid_pc4;
            r_valid   <= 1'b1;
            r_state   <= FETCH;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  assign Instruction = r_instr;
  assign OpCode      = r_opcode;
  assign PCPlus4     = r_pcplus4;
  assign InstrValid  = r_valid;

endmodule

`default_nettype wire
